miriscv_uart_tx: RTL and testbench
==================================

// Module: miriscv_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the miriscv core's data bus. The core initiates
//  load/store requests; this block is the responder: it decodes a 4-word register
//  window, buffers bytes in a FIFO and serialises them on tx_o. Sits beside the RAM in
//  miriscv_top, selected by an external address decoder.
// PARAMETERS
//  FIFO_DEPTH   8        TX FIFO entries, power of 2, >= 2
//  DEFAULT_DIV  16'd867  reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous reset, active-high
//  data_req_i     in   1   request strobe, already qualified by address decoder
//  data_we_i      in   1   1 = write, 0 = read
//  data_be_i      in   4   byte enables
//  data_addr_i    in   32  byte address; only [3:2] decoded
//  data_wdata_i   in   32  write data
//  data_rdata_o   out  32  read data, valid with data_rvalid_o
//  data_rvalid_o  out  1   response pulse, one cycle after every accepted req
//  tx_o           out  1   serial line, idle high
//  irq_o          out  1   level: FIFO empty AND FSM idle AND CTRL.EN
// BEHAVIOUR
//  Reset: data_rdata_o=0, data_rvalid_o=0, tx_o=1, irq_o=0, FIFO empty, OVF=0,
//   BAUDDIV=DEFAULT_DIV, CTRL=0, FSM=IDLE. Reset mid-frame aborts: tx_o=1 next edge.
//  Bus: every req accepted same cycle (no stall); data_rvalid_o=1 the next cycle,
//   for reads and writes; data_rdata_o registered, 0 for writes.
//  Register map (addr[3:2]):
//   00 TXDATA  W : be[0] write pushes wdata[7:0]; reads return 0
//   01 STATUS  R : {28'b0, ovf, busy, full, empty}; write with be[0] and wdata[3]=1 clears ovf
//   10 BAUDDIV RW: [15:0], byte-lane writes via be[1:0]; upper bits read 0
//   11 CTRL    RW: bit0 EN; be[0] gates write
//  FIFO: push on TXDATA write when not full; full sampled before same-cycle pop, so a
//   write while full is dropped and sets sticky ovf even if FSM pops that cycle.
//   Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  FSM: IDLE -> START when EN & !empty (pop, latch byte) ; START -> DATA after one bit
//   period ; DATA sends bits 0..7 LSB first, bit index 3-bit counter ;
//   DATA -> [PARITY] -> STOP ; STOP -> START if EN & !empty (back-to-back, no idle
//   gap) else IDLE. tx_o: START=0, DATA=bit, PARITY=even parity, STOP/IDLE=1.
//  Baud counter: 16-bit down-counter loaded with BAUDDIV at every bit start; bit ends
//   when counter==0. BAUDDIV=0 gives 1-cycle bits. BAUDDIV write mid-frame applies from
//   next bit boundary. busy=1 in every state except IDLE.
//  EN cleared mid-frame: current frame completes, FSM returns to IDLE, FIFO retained.
//  Simultaneous push+pop when not full: both happen, count unchanged.
// CONFIGURATION
//  MIRISCV_UART_PARITY_EN defined: PARITY state present, frame = 11 bits, parity bit =
//   XOR of data bits (even). Undefined: no PARITY state, DATA -> STOP, frame = 10 bits.
// TESTING
//  Reset, read STATUS -> rdata=0x1 (empty), rvalid one cycle after req, tx_o=1.
//  BAUDDIV=3, EN=1, write TXDATA 0xA5 -> tx_o: 0, 1,0,1,0,0,1,0,1, [0], 1; 4 clks/bit.
//  EN=0, write 9 bytes with FIFO_DEPTH=8 -> STATUS=0xA (ovf,full); write 0x8 -> ovf clears.
//  EN=1 with 3 queued bytes, BAUDDIV=0 -> three frames back-to-back, no idle cycles; irq_o rises after last stop.
//  Assert rst_i during bit 4 of a frame -> tx_o=1 next edge, STATUS=0x1, BAUDDIV=867.
//  Clear EN during DATA of frame 1 with 2 queued -> frame 1 completes, FSM IDLE, STATUS=0x0 (1 byte left).

Source files
------------

// File: rtl/miriscv_uart_tx.sv
// miriscv_uart_tx: memory-mapped UART transmitter that responds on the miriscv data bus.
// It decodes a 4-word register window (TXDATA, STATUS, BAUDDIV, CTRL), queues bytes
// in a small FIFO and serialises them LSB first on tx_o with one start and one stop bit.
// Optional feature macro: MIRISCV_UART_PARITY_EN adds an even-parity bit after the data
// bits, giving 11-bit frames. Without it, frames are 10 bits.
module miriscv_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_rvalid_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Bus-side registers
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic [15:0]   r_baud_div;
    logic          r_en;
    logic          r_ovf;

    // FIFO storage and pointers
    logic [7:0]    r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Serialiser state
    state_t        r_state;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
`ifdef MIRISCV_UART_PARITY_EN
    logic          r_parity;
`endif

    logic [1:0]    w_addr;
    logic          w_wr;
    logic          w_rd;
    logic          w_empty;
    logic          w_full;
    logic          w_busy;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_bit_end;
    logic          w_pop;
    logic [31:0]   w_rd_mux;
    logic          w_unused_bits;

    assign w_addr     = data_addr_i[3:2];
    assign w_wr       = data_req_i & data_we_i;
    assign w_rd       = data_req_i & ~data_we_i;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_busy     = (r_state != S_IDLE);
    // Full is judged on the pre-pop count, so a write while full is always dropped
    assign w_push_req = w_wr & (w_addr == 2'd0) & data_be_i[0];
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf_set  = w_push_req & w_full;
    assign w_ovf_clr  = w_wr & (w_addr == 2'd1) & data_be_i[0] & data_wdata_i[3];
    assign w_bit_end  = (r_baud_cnt == 16'd0);
    // A new frame is fetched from idle, or straight out of the stop bit for back-to-back frames
    assign w_pop      = ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end))
                        & r_en & ~w_empty;

    assign w_unused_bits = ^{data_addr_i[31:4], data_addr_i[1:0], data_wdata_i[31:16]};

    assign data_rdata_o  = r_rdata;
    assign data_rvalid_o = r_rvalid;
    assign tx_o          = r_tx;
    assign irq_o         = w_empty & ~w_busy & r_en;

    // Read data multiplexer over the register window
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_addr)
            2'd1:    w_rd_mux = {28'd0, r_ovf, w_busy, w_full, w_empty};
            2'd2:    w_rd_mux = {16'd0, r_baud_div};
            2'd3:    w_rd_mux = {31'd0, r_en};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Bus response: every request answered one cycle later, read data zero for writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= data_req_i;
            r_rdata  <= w_rd ? w_rd_mux : 32'd0;
        end
    end

    // Configuration registers and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_baud_div <= DEFAULT_DIV;
            r_en       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (w_addr == 2'd2)) begin
                for (int i = 0; i < 2; i++) begin
                    if (data_be_i[i]) begin
                        r_baud_div[i*8 +: 8] <= data_wdata_i[i*8 +: 8];
                    end
                end
            end
            if (w_wr && (w_addr == 2'd3) && data_be_i[0]) begin
                r_en <= data_wdata_i[0];
            end
        end
    end

    // FIFO storage write port (contents need no reset)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= data_wdata_i[7:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Frame serialiser; the baud counter reloads from BAUDDIV at every bit start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
`ifdef MIRISCV_UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_state    <= S_START;
                r_baud_cnt <= r_baud_div;
                r_shift    <= r_fifo_mem[r_rd_ptr];
                r_tx       <= 1'b0;
`ifdef MIRISCV_UART_PARITY_EN
                r_parity   <= ^r_fifo_mem[r_rd_ptr];
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_state    <= S_DATA;
                            r_baud_cnt <= r_baud_div;
                            r_bit_idx  <= 3'd0;
                            r_tx       <= r_shift[0];
                            r_shift    <= {1'b0, r_shift[7:1]};
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 16'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= r_baud_div;
                            if (r_bit_idx == 3'd7) begin
`ifdef MIRISCV_UART_PARITY_EN
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
`else
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                r_tx      <= r_shift[0];
                                r_shift   <= {1'b0, r_shift[7:1]};
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 16'd1;
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= S_STOP;
                            r_baud_cnt <= r_baud_div;
                            r_tx       <= 1'b1;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 16'd1;
                        end
                    end
                    S_STOP: begin
                        // Reaching here at bit end means no frame was fetched: go idle
                        if (w_bit_end) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - 16'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// tb_miriscv_uart_tx: directed bench for miriscv_uart_tx with hand-computed expectations.
// Honours MIRISCV_UART_PARITY_EN for the expected frame length and parity bit.
module tb_miriscv_uart_tx;

`ifdef MIRISCV_UART_PARITY_EN
    localparam int FRAME_LEN = 11;
    localparam logic [10:0] EXP_A5 = 11'b1_0_1010_0101_0;
`else
    localparam int FRAME_LEN = 10;
    localparam logic [10:0] EXP_A5 = 11'b0_1_1010_0101_0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        tx;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_rvalid;
    logic [31:0] last_rdata;
    logic [31:0] d;
    logic [10:0] exp_a5;
    logic [10:0] fr;
    logic [7:0]  b2b_bytes [3];

    always #5 clk = ~clk;

    miriscv_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (req),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .data_rdata_o  (rdata),
        .data_rvalid_o (rvalid),
        .tx_o          (tx),
        .irq_o         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] v);
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = b; addr = a; wdata = v;
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'd0;
        last_rvalid = rvalid;
        last_rdata  = rdata;
        $display("WR addr=0x%0h be=0x%0h data=0x%0h", a, b, v);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = a;
        @(negedge clk);
        req = 1'b0; be = 4'd0;
        last_rvalid = rvalid;
        v = rdata;
        $display("RD addr=0x%0h data=0x%0h", a, v);
    endtask

    task automatic wait_tx_low(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (tx == 1'b0) break;
            @(negedge clk);
        end
        chk(tag, {31'd0, tx}, 32'd0);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] v);
`ifdef MIRISCV_UART_PARITY_EN
        return {1'b1, ^v, v, 1'b0};
`else
        return {1'b0, 1'b1, v, 1'b0};
`endif
    endfunction

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
        last_rvalid = 1'b0; last_rdata = 32'd0;
        exp_a5 = EXP_A5;
        b2b_bytes[0] = 8'h3C; b2b_bytes[1] = 8'h81; b2b_bytes[2] = 8'h7E;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst = 1'b0;
        bus_read(32'h4, d);
        chk("status after reset", d, 32'h1);
        chk("read rvalid", {31'd0, last_rvalid}, 32'd1);
        @(negedge clk);
        chk("rvalid single pulse", {31'd0, rvalid}, 32'd0);
        bus_read(32'h8, d);
        chk("bauddiv default", d, 32'd867);

        // BAUDDIV byte lanes
        bus_write(32'h8, 4'hF, 32'hFFFF_FFFF);
        chk("write rvalid", {31'd0, last_rvalid}, 32'd1);
        chk("write rdata zero", last_rdata, 32'd0);
        bus_read(32'h8, d);
        chk("bauddiv upper zero", d, 32'h0000_FFFF);
        bus_write(32'h8, 4'b0001, 32'h0000_0003);
        bus_read(32'h8, d);
        chk("bauddiv lane0", d, 32'h0000_FF03);
        bus_write(32'h8, 4'b0010, 32'h0000_0000);
        bus_read(32'h8, d);
        chk("bauddiv lane1", d, 32'h0000_0003);

        // Single frame 0xA5 at 4 clocks per bit
        bus_write(32'hC, 4'h1, 32'h1);
        bus_write(32'h0, 4'h1, 32'hA5);
        wait_tx_low(20, "A5 start seen");
        chk("irq low while busy", {31'd0, irq}, 32'd0);
        for (int b = 0; b < FRAME_LEN; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("A5 bit%0d cyc%0d", b, c), {31'd0, tx}, {31'd0, exp_a5[b]});
                @(negedge clk);
            end
        end
        chk("irq after A5", {31'd0, irq}, 32'd1);
        chk("tx idle after A5", {31'd0, tx}, 32'd1);
        bus_read(32'h0, d);
        chk("txdata reads zero", d, 32'd0);

        // Overflow with EN=0
        bus_write(32'hC, 4'h1, 32'h0);
        chk("irq needs en", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) bus_write(32'h0, 4'h1, 32'h30 + i);
        bus_read(32'h4, d);
        chk("status full", d, 32'h2);
        bus_write(32'h0, 4'h1, 32'h99);
        bus_read(32'h4, d);
        chk("status ovf full", d, 32'hA);
        bus_write(32'h4, 4'h1, 32'h8);
        bus_read(32'h4, d);
        chk("status ovf cleared", d, 32'h2);

        // Reset empties FIFO
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(32'h4, d);
        chk("status after reset 2", d, 32'h1);

        // Three back-to-back frames at 1 clock per bit
        bus_write(32'h8, 4'h3, 32'h0);
        for (int i = 0; i < 3; i++) bus_write(32'h0, 4'h1, {24'd0, b2b_bytes[i]});
        bus_write(32'hC, 4'h1, 32'h1);
        wait_tx_low(10, "b2b start seen");
        for (int f = 0; f < 3; f++) begin
            fr = frame_of(b2b_bytes[f]);
            for (int b = 0; b < FRAME_LEN; b++) begin
                chk($sformatf("b2b f%0d bit%0d", f, b), {31'd0, tx}, {31'd0, fr[b]});
                if (f == 2 && b == FRAME_LEN - 1)
                    chk("irq low in last stop", {31'd0, irq}, 32'd0);
                @(negedge clk);
            end
        end
        chk("irq after b2b", {31'd0, irq}, 32'd1);

        // Reset during data bit 4
        bus_write(32'hC, 4'h1, 32'h0);
        bus_write(32'h8, 4'h3, 32'h3);
        bus_write(32'h0, 4'h1, 32'h0F);
        bus_write(32'h0, 4'h1, 32'h55);
        bus_write(32'hC, 4'h1, 32'h1);
        wait_tx_low(20, "0F start seen");
        repeat (20) @(negedge clk);
        chk("0F bit4 low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("tx high after mid-frame reset", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(32'h4, d);
        chk("status after mid reset", d, 32'h1);
        bus_read(32'h8, d);
        chk("bauddiv after mid reset", d, 32'd867);
        bus_read(32'hC, d);
        chk("ctrl after mid reset", d, 32'h0);

        // EN cleared during DATA of frame 1 with 2 queued
        bus_write(32'h8, 4'h3, 32'h3);
        bus_write(32'h0, 4'h1, 32'h11);
        bus_write(32'h0, 4'h1, 32'h22);
        bus_write(32'hC, 4'h1, 32'h1);
        wait_tx_low(20, "11 start seen");
        repeat (8) @(negedge clk);
        bus_write(32'hC, 4'h1, 32'h0);
        bus_read(32'h4, d);
        chk("busy mid frame", d, 32'h4);
        for (int i = 0; i < 100; i++) begin
            bus_read(32'h4, d);
            if (d[2] == 1'b0) break;
        end
        chk("status after en clear", d, 32'h0);
        repeat (20) @(negedge clk);
        chk("tx idle after en clear", {31'd0, tx}, 32'd1);
        bus_read(32'h4, d);
        chk("byte retained", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
